// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage holds at most one request outstanding on this bus.
interface fetch_unit_if #(
  parameter int WORD_W = 32
);
  logic              req;
  logic [WORD_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [WORD_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues fetches to imem, and presents
// instrF/pcF/validF to the IF/ID register. It honours stallF and redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WORD_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallF,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  fetch_unit_if.master      imem,
  output logic [WORD_W-1:0] instrF,
  output logic [WORD_W-1:0] pcF,
  output logic              validF,
  output logic              fetch_busy
);
  localparam logic [WORD_W-1:0] ZERO_WORD = '0;
  localparam logic [WORD_W-1:0] PC_STEP   = WORD_W'(4);
  localparam logic [WORD_W-1:0] PC_INIT   = WORD_W'(RESET_PC);

  typedef enum logic [1:0] {FETCH, WAIT, FULL} state_t;

  state_t            state_reg;
  logic [WORD_W-1:0] pc_reg;
  logic [WORD_W-1:0] pc_inflight_reg;
  logic              kill_reg;
  logic [WORD_W-1:0] instr_reg;
  logic [WORD_W-1:0] pcf_reg;
  logic              valid_reg;

  // A request is never issued in WAIT, so at most one is outstanding.
  assign imem.req   = !redirect && ((state_reg == FETCH) || ((state_reg == FULL) && !stallF));
  assign imem.addr  = pc_reg;
  assign instrF     = instr_reg;
  assign pcF        = pcf_reg;
  assign validF     = valid_reg;
  assign fetch_busy = !valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= FETCH;
      pc_reg          <= PC_INIT;
      pc_inflight_reg <= PC_INIT;
      kill_reg        <= 1'b0;
      instr_reg       <= ZERO_WORD;
      pcf_reg         <= PC_INIT;
      valid_reg       <= 1'b0;
    end else if (redirect) begin
      pc_reg    <= redirect_pc;
      valid_reg <= 1'b0;
      instr_reg <= ZERO_WORD;
      if (state_reg == WAIT) begin
        // The response to the in-flight request is still owed; drop exactly one.
        if (imem.rvalid) begin
          kill_reg  <= 1'b0;
          state_reg <= FETCH;
        end else begin
          kill_reg  <= 1'b1;
        end
      end else begin
        state_reg <= FETCH;
      end
    end else begin
      case (state_reg)
        FETCH: begin
          if (imem.gnt) begin
            pc_inflight_reg <= pc_reg;
            state_reg       <= WAIT;
          end
        end
        WAIT: begin
          if (imem.rvalid) begin
            if (kill_reg) begin
              kill_reg  <= 1'b0;
              state_reg <= FETCH;
            end else begin
              instr_reg <= imem.rdata;
              pcf_reg   <= pc_inflight_reg;
              valid_reg <= 1'b1;
              pc_reg    <= pc_inflight_reg + PC_STEP;
              state_reg <= FULL;
            end
          end
        end
        FULL: begin
          if (!stallF) begin
            valid_reg <= 1'b0;
            instr_reg <= ZERO_WORD;
            if (imem.gnt) begin
              pc_inflight_reg <= pc_reg;
              state_reg       <= WAIT;
            end else begin
              state_reg       <= FETCH;
            end
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: per-cycle input/expected-output
// records plus hand-written redirect, wrap-around and async-reset sequences.
module tb_fetch_unit;
  logic        clk;
  logic        rst;
  logic        stallF;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic        validF;
  logic        fetch_busy;

  int tests_run;
  int tests_failed;

  fetch_unit_if #(.WORD_W(32)) imem_bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .WORD_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallF      (stallF),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus.master),
    .instrF      (instrF),
    .pcF         (pcF),
    .validF      (validF),
    .fetch_busy  (fetch_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pcf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and check outputs before the rising edge.
  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    stallF          = v.st;
    redirect        = v.rd;
    redirect_pc     = v.rpc;
    imem_bus.gnt    = v.gnt;
    imem_bus.rvalid = v.rv;
    imem_bus.rdata  = v.rdata;
    #1;
    $display("[TB] %s req=%b addr=%h valid=%b instr=%h pcF=%h",
             tag, imem_bus.req, imem_bus.addr, validF, instrF, pcF);
    chk({tag, ".req"},   32'(imem_bus.req), 32'(v.e_req));
    chk({tag, ".addr"},  imem_bus.addr,     v.e_addr);
    chk({tag, ".valid"}, 32'(validF),       32'(v.e_valid));
    chk({tag, ".busy"},  32'(fetch_busy),   32'(!v.e_valid));
    chk({tag, ".instr"}, instrF,            v.e_instr);
    chk({tag, ".pcF"},   pcF,               v.e_pcf);
  endtask

  vec_t tbl[16];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    stallF       = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = 32'h0;

    //            st  rd  rpc  gnt rv  rdata          req addr        v   instr          pcF
    tbl[0]  = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,         1'b1,32'h0,      1'b0,32'h0,         32'h0};
    tbl[1]  = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,         1'b1,32'h0,      1'b0,32'h0,         32'h0};
    tbl[2]  = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,         1'b1,32'h0,      1'b0,32'h0,         32'h0};
    tbl[3]  = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,         1'b1,32'h0,      1'b0,32'h0,         32'h0};
    tbl[4]  = '{1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,         1'b1,32'h0,      1'b0,32'h0,         32'h0};
    tbl[5]  = '{1'b0,1'b0,32'h0,1'b0,1'b1,32'h2008_0005, 1'b0,32'h0,      1'b0,32'h0,         32'h0};
    tbl[6]  = '{1'b1,1'b0,32'h0,1'b0,1'b1,32'hBAD0_BAD0, 1'b0,32'h4,      1'b1,32'h2008_0005, 32'h0};
    tbl[7]  = '{1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,         1'b0,32'h4,      1'b1,32'h2008_0005, 32'h0};
    tbl[8]  = '{1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,         1'b0,32'h4,      1'b1,32'h2008_0005, 32'h0};
    tbl[9]  = '{1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,         1'b1,32'h4,      1'b1,32'h2008_0005, 32'h0};
    tbl[10] = '{1'b0,1'b0,32'h0,1'b0,1'b1,32'h1111_0001, 1'b0,32'h4,      1'b0,32'h0,         32'h0};
    tbl[11] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,         1'b1,32'h8,      1'b1,32'h1111_0001, 32'h4};
    tbl[12] = '{1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,         1'b1,32'h8,      1'b0,32'h0,         32'h4};
    tbl[13] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,         1'b0,32'h8,      1'b0,32'h0,         32'h4};
    tbl[14] = '{1'b0,1'b0,32'h0,1'b0,1'b1,32'h2222_0002, 1'b0,32'h8,      1'b0,32'h0,         32'h4};
    tbl[15] = '{1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,         1'b0,32'hC,      1'b1,32'h2222_0002, 32'h8};

    // Reset state while rst is held low.
    @(negedge clk);
    #1;
    $display("[TB] reset valid=%b instr=%h pcF=%h addr=%h", validF, instrF, pcF, imem_bus.addr);
    chk("reset.valid", 32'(validF),     32'h0);
    chk("reset.busy",  32'(fetch_busy), 32'h1);
    chk("reset.instr", instrF,          32'h0);
    chk("reset.pcF",   pcF,             32'h0);
    chk("reset.addr",  imem_bus.addr,   32'h0);
    rst = 1'b1;

    // Gnt held off, first fetch, stall hold with stray rvalid, consumption.
    for (int i = 0; i < 16; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Redirect while waiting, then a second redirect: only one response is dropped.
    step("rdw0", '{1'b0,1'b0,32'h0,  1'b1,1'b0,32'h0,        1'b1,32'hC,  1'b1,32'h2222_0002,32'h8});
    step("rdw1", '{1'b0,1'b1,32'h100,1'b0,1'b0,32'h0,        1'b0,32'hC,  1'b0,32'h0,        32'h8});
    step("rdw2", '{1'b0,1'b1,32'h200,1'b0,1'b0,32'h0,        1'b0,32'h100,1'b0,32'h0,        32'h8});
    step("rdw3", '{1'b0,1'b0,32'h0,  1'b0,1'b1,32'hDEAD_BEEF,1'b0,32'h200,1'b0,32'h0,        32'h8});
    step("rdw4", '{1'b0,1'b0,32'h0,  1'b1,1'b0,32'h0,        1'b1,32'h200,1'b0,32'h0,        32'h8});
    step("rdw5", '{1'b0,1'b0,32'h0,  1'b0,1'b1,32'h3333_0003,1'b0,32'h200,1'b0,32'h0,        32'h8});
    step("rdw6", '{1'b1,1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0,32'h204,1'b1,32'h3333_0003,32'h200});

    // Redirect in the same cycle as the response.
    step("rdr0", '{1'b0,1'b0,32'h0,  1'b1,1'b0,32'h0,        1'b1,32'h204,1'b1,32'h3333_0003,32'h200});
    step("rdr1", '{1'b0,1'b1,32'h400,1'b0,1'b1,32'h4444_0004,1'b0,32'h204,1'b0,32'h0,        32'h200});
    step("rdr2", '{1'b0,1'b0,32'h0,  1'b1,1'b0,32'h0,        1'b1,32'h400,1'b0,32'h0,        32'h200});
    step("rdr3", '{1'b0,1'b0,32'h0,  1'b0,1'b1,32'h5555_0005,1'b0,32'h400,1'b0,32'h0,        32'h200});
    step("rdr4", '{1'b1,1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0,32'h404,1'b1,32'h5555_0005,32'h400});

    // Fetch from the top word, PC wraps to zero.
    step("wrp0", '{1'b0,1'b1,32'hFFFF_FFFC,1'b0,1'b0,32'h0,  1'b0,32'h404,1'b1,32'h5555_0005,32'h400});
    step("wrp1", '{1'b0,1'b0,32'h0,  1'b1,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,1'b0,32'h0,  32'h400});
    step("wrp2", '{1'b0,1'b0,32'h0,  1'b0,1'b1,32'h6666_0006,1'b0,32'hFFFF_FFFC,1'b0,32'h0,  32'h400});
    step("wrp3", '{1'b0,1'b0,32'h0,  1'b1,1'b0,32'h0,        1'b1,32'h0,  1'b1,32'h6666_0006,32'hFFFF_FFFC});
    step("wrp4", '{1'b0,1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b0,32'h0,        32'hFFFF_FFFC});

    // Asynchronous reset mid-WAIT, takes effect without a clock edge.
    #2 rst = 1'b0;
    #1;
    $display("[TB] async-reset valid=%b instr=%h pcF=%h addr=%h req=%b",
             validF, instrF, pcF, imem_bus.addr, imem_bus.req);
    chk("arst.valid", 32'(validF),       32'h0);
    chk("arst.instr", instrF,            32'h0);
    chk("arst.pcF",   pcF,               32'h0);
    chk("arst.addr",  imem_bus.addr,     32'h0);
    chk("arst.req",   32'(imem_bus.req), 32'h1);
    @(negedge clk);
    rst = 1'b1;

    // Late response to the pre-reset request must be ignored.
    step("late0", '{1'b0,1'b0,32'h0, 1'b0,1'b1,32'h7777_0007,1'b1,32'h0,  1'b0,32'h0,        32'h0});
    step("late1", '{1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,        1'b1,32'h0,  1'b0,32'h0,        32'h0});
    step("late2", '{1'b0,1'b0,32'h0, 1'b0,1'b1,32'h8888_0008,1'b0,32'h0,  1'b0,32'h0,        32'h0});
    step("late3", '{1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,        1'b0,32'h4,  1'b1,32'h8888_0008,32'h0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
